fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
Decoupled fetch front-end for the pipelined core. It sits upstream of decode and owns the PC. It issues word requests to the synchronous instruction memory and captures returned words into a small FIFO. It presents {pc, insn} to decode through a valid/ready handshake. On a redirect from execute it flushes everything queued and in flight, then restarts fetch at the target address.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, instruction width
BASEADDR, 32'h01000000, PC value after reset
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
redirect_i  in  1  branch/jump taken; restart fetch at redirect_pc_i
redirect_pc_i  in  AWIDTH  redirect target; bits [1:0] are ignored and forced to 0
imem_req_o  in→out  1  request strobe to the instruction memory (output)
imem_addr_o  out  AWIDTH  request address (word aligned)
imem_data_i  in  DWIDTH  read data, valid exactly one cycle after the request
out_valid_o  out  1  buffer head is valid
out_pc_o  out  AWIDTH  PC of the head entry
out_insn_o  out  DWIDTH  instruction word of the head entry
out_ready_i  in  1  decode accepts the head entry
flush_cnt_o  out  8  saturating count of redirects, for debug and probes

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - fetch_pc = BASEADDR
  - FIFO empty; inflight = 0
  - imem_req_o = 0, out_valid_o = 0, flush_cnt_o = 0
  - out_pc_o and out_insn_o = 0
- imem latency is fixed at 1 cycle:
  - A request in cycle N returns imem_data_i in cycle N+1.
  - The internal inflight flag marks that cycle; inflight_pc holds the requested PC.
- Issue rule, evaluated each cycle:
  - imem_req_o = !redirect_i && (count + inflight - pop < DEPTH), where pop = out_valid_o && out_ready_i.
  - imem_addr_o = fetch_pc.
  - When a request issues: fetch_pc += 4, wrapping modulo 2^AWIDTH.
- Capture:
  - When inflight && !redirect_i, push {inflight_pc, imem_data_i} into the FIFO.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - The issue rule guarantees no push ever arrives while the FIFO is full. The bench asserts this.
- Output:
  - out_valid_o = (count != 0) && !redirect_i.
  - out_pc_o and out_insn_o show the head entry. They are 0 when the FIFO is empty.
  - A transfer happens only when out_valid_o && out_ready_i.
  - While out_ready_i = 0, the head and its fields stay stable.
- Redirect, cycle N with redirect_i = 1:
  - No handshake and no request occur in cycle N.
  - At the end of N: FIFO pointers clear, count = 0, inflight = 0 (in-flight data is dropped), fetch_pc = {redirect_pc_i[AWIDTH-1:2], 2'b00}, flush_cnt_o increments and saturates at 255.
  - N+1: request at the target.
  - N+2: data captured.
  - N+3: out_valid_o = 1 with out_pc_o = target. Redirect-to-valid latency is 3 cycles.
- Back-to-back redirects: the last one wins. Each one re-flushes the buffer and increments flush_cnt_o.
- Throughput: with out_ready_i held at 1, the block sustains one instruction per cycle in steady state. The first valid appears 2 cycles after reset deassertion.
- Reset mid-operation: everything returns immediately to reset values, including discarding any in-flight data. Fetch restarts at BASEADDR.

Decomposition:
- Shared constants package holds:
  - the BASEADDR default
  - the instruction-word width
  - a fetch_entry_t packed struct {pc, insn}
- One sub-module, insn_fifo:
  - parameterised on DEPTH and entry type
  - ports: push, pop, clear, count, head
  - asynchronous reset
- PC, inflight and issue logic stay in fetch_buffer.

Test Plan:
1. Reset release with out_ready_i = 1 and imem returning addr^32'hA5A5A5A5 → out_pc_o sequence 01000000, 01000004, 01000008… one per cycle from cycle 2; data matches.
2. out_ready_i = 0 for 10 cycles → imem_req_o drops after exactly DEPTH=4 entries are filled or in flight; out_pc_o holds 01000000. Release → four entries drain in order with no gaps, then fetch resumes.
3. Redirect to 01000102 while the FIFO holds 3 entries → out_valid_o = 0 for cycles N..N+2; N+1 shows imem_addr_o = 01000100; N+3 shows out_pc_o = 01000100; flush_cnt_o = 1; no stale entry ever appears.
4. Two redirects in consecutive cycles (targets 01000200, then 01000300) → only 01000300 is fetched; flush_cnt_o = 2.
5. Redirect to FFFFFFFC → output PCs FFFFFFFC then 00000000 (wrap).
6. Assert rst mid-stream with a request in flight → out_valid_o and imem_req_o go to 0 immediately; after release, the first output PC is 01000000.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared constants and types for the fetch front-end.
package fetch_buffer_pkg;

  localparam int                   FB_AWIDTH   = 32;
  localparam int                   FB_DWIDTH   = 32;
  localparam int                   FB_DEPTH    = 4;
  localparam logic [FB_AWIDTH-1:0] FB_BASEADDR = 32'h0100_0000;

  // One buffered fetch: the word and the PC it was fetched from.
  typedef struct packed {
    logic [FB_AWIDTH-1:0] pc;
    logic [FB_DWIDTH-1:0] insn;
  } fetch_entry_t;

  // Saturating increment for the 8-bit redirect counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_buffer_insn_fifo.sv
// Small circular FIFO of fetch entries with a synchronous clear.
module insn_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int  DEPTH = FB_DEPTH,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  T              data_i,
  output logic [CW-1:0] count_o,
  output T              head_o
);

  localparam int PW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer and count next state; clear wins over any push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer/count state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents are only observed through the count, so no reset.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_buffer.sv
// Decoupled fetch front-end: owns the PC, issues imem requests, buffers
// returned words and hands {pc, insn} to decode. Redirect flushes all.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int                AWIDTH   = FB_AWIDTH,
  parameter int                DWIDTH   = FB_DWIDTH,
  parameter logic [AWIDTH-1:0] BASEADDR = FB_BASEADDR,
  parameter int                DEPTH    = FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic [DWIDTH-1:0] imem_data_i,
  output logic              out_valid_o,
  output logic [AWIDTH-1:0] out_pc_o,
  output logic [DWIDTH-1:0] out_insn_o,
  input  logic              out_ready_i,
  output logic [7:0]        flush_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);

  // Entry layout sized to this instance's widths.
  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [AWIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [7:0]        flush_cnt_q, flush_cnt_d;

  logic [CW-1:0]     fifo_cnt;
  entry_t            head, push_entry;
  logic              push, pop, req, empty;
  logic [CW:0]       occ;

  assign empty = (fifo_cnt == '0);
  assign pop   = out_valid_o && out_ready_i;
  assign push  = inflight_q && !redirect_i;

  // Slots committed after this cycle: buffered + returning - leaving.
  // A pop implies a non-empty FIFO, so this never underflows.
  assign occ = {1'b0, fifo_cnt} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign req = !rst && !redirect_i && (occ < (CW+1)'(DEPTH));

  assign push_entry = '{pc: inflight_pc_q, insn: imem_data_i};

  // PC, in-flight tracking and redirect counter next state.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    flush_cnt_d   = flush_cnt_q;
    if (redirect_i) begin
      fetch_pc_d  = {redirect_pc_i[AWIDTH-1:2], 2'b00};
      flush_cnt_d = sat_inc8(flush_cnt_q);
    end else if (req) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + AWIDTH'(4);
    end
  end

  // Front-end state with asynchronous reset; in-flight data is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= BASEADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      flush_cnt_q   <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  insn_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect_i),
    .data_i  (push_entry),
    .count_o (fifo_cnt),
    .head_o  (head)
  );

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;
  assign out_valid_o = !empty && !redirect_i;
  assign out_pc_o    = empty ? '0 : head.pc;
  assign out_insn_o  = empty ? '0 : head.insn;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized and directed bench for fetch_buffer against a queue model.
module tb_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] K     = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i = '0;
  logic        out_valid_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_insn_o;
  logic        out_ready_i = 1'b0;
  logic [7:0]  flush_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  fetch_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .out_valid_o   (out_valid_o),
    .out_pc_o      (out_pc_o),
    .out_insn_o    (out_insn_o),
    .out_ready_i   (out_ready_i),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Synchronous imem: word for the address seen at this edge, one cycle later.
  always @(posedge clk) imem_data_i <= imem_addr_o ^ K;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: list of PCs buffered, plus one optional returning PC.
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_ipc, m_pc;
  int          m_flush;
  bit          m_pop, m_req;

  task automatic m_reset();
    mq.delete();
    m_infl  = 0;
    m_ipc   = '0;
    m_pc    = BASE;
    m_flush = 0;
  endtask

  // Drive this cycle's inputs and compare all outputs with the model.
  task automatic set(input bit r, input logic [31:0] tpc, input bit rdy);
    bit          ev;
    logic [31:0] hp;
    redirect_i    = r;
    redirect_pc_i = tpc;
    out_ready_i   = rdy;
    #1;
    ev    = (mq.size() != 0) && !r;
    hp    = (mq.size() != 0) ? mq[0] : 32'h0;
    m_pop = ev && rdy;
    m_req = !r && ((mq.size() + int'(m_infl) - int'(m_pop)) < DEPTH);
    chk("valid", out_valid_o, ev);
    chk("pc",    out_pc_o, hp);
    chk("insn",  out_insn_o, (mq.size() != 0) ? (hp ^ K) : 32'h0);
    chk("req",   imem_req_o, m_req);
    chk("addr",  imem_addr_o, m_pc);
    chk("flush", flush_cnt_o, m_flush);
    chk("nofull", !(dut.inflight_q && !r && int'(dut.fifo_cnt) == DEPTH &&
                    !(out_valid_o && out_ready_i)), 1'b1);
  endtask

  // Advance the model across the coming clock edge.
  task automatic adv();
    if (redirect_i) begin
      mq.delete();
      m_infl = 0;
      m_pc   = redirect_pc_i & ~32'h3;
      if (m_flush < 255) m_flush++;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_ipc);
      m_infl = m_req;
      if (m_req) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input bit r, input logic [31:0] tpc, input bit rdy);
    set(r, tpc, rdy);
    adv();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req",   imem_req_o, 1'b0);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_pc",    out_pc_o, 32'h0);
    chk("rst_insn",  out_insn_o, 32'h0);
    chk("rst_flush", flush_cnt_o, 8'h0);
    chk("rst_addr",  imem_addr_o, BASE);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_i = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();

    // Streaming from reset: first valid two cycles after release.
    step(0, 0, 1);
    step(0, 0, 1);
    set(0, 0, 1);
    chk("t1_first_valid", out_valid_o, 1'b1);
    chk("t1_first_pc", out_pc_o, BASE);
    adv();
    set(0, 0, 1);
    chk("t1_second_pc", out_pc_o, BASE + 32'd4);
    chk("t1_second_insn", out_insn_o, (BASE + 32'd4) ^ K);
    adv();
    for (int i = 0; i < 6; i++) step(0, 0, 1);

    // Back-pressure: fill then drain.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 0, 0);
    set(0, 0, 0);
    chk("t2_hold_pc", out_pc_o, BASE);
    chk("t2_req_low", imem_req_o, 1'b0);
    adv();
    for (int i = 0; i < 10; i++) step(0, 0, 1);

    // Redirect with three entries buffered and one in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    set(1, 32'h0100_0102, 1);
    chk("t3_valid_n", out_valid_o, 1'b0);
    adv();
    set(0, 0, 1);
    chk("t3_addr_n1", imem_addr_o, 32'h0100_0100);
    chk("t3_req_n1", imem_req_o, 1'b1);
    adv();
    step(0, 0, 1);
    set(0, 0, 1);
    chk("t3_valid_n3", out_valid_o, 1'b1);
    chk("t3_pc_n3", out_pc_o, 32'h0100_0100);
    chk("t3_flush", flush_cnt_o, 8'd1);
    adv();
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // Back-to-back redirects: last one wins.
    do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'h0100_0200, 1);
    step(1, 32'h0100_0300, 1);
    set(0, 0, 1);
    chk("t4_addr", imem_addr_o, 32'h0100_0300);
    chk("t4_flush", flush_cnt_o, 8'd2);
    adv();
    step(0, 0, 1);
    set(0, 0, 1);
    chk("t4_pc", out_pc_o, 32'h0100_0300);
    adv();
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Address wrap.
    step(1, 32'hFFFF_FFFC, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    set(0, 0, 1);
    chk("t5_pc_top", out_pc_o, 32'hFFFF_FFFC);
    adv();
    set(0, 0, 1);
    chk("t5_valid_wrap", out_valid_o, 1'b1);
    chk("t5_pc_wrap", out_pc_o, 32'h0);
    adv();

    // Reset mid-stream with a request in flight.
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("t6_inflight", dut.inflight_q, 1'b1);
    do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    set(0, 0, 1);
    chk("t6_first_pc", out_pc_o, BASE);
    adv();

    // Redirect counter saturation.
    for (int i = 0; i < 260; i++) step(1, $urandom, $urandom_range(0, 1) == 1);
    set(0, 0, 1);
    chk("sat_flush", flush_cnt_o, 8'd255);
    adv();

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tpc;
      tpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 15) == 0, tpc, $urandom_range(0, 3) != 0);
      if (i % 500 == 250) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
